// File: rtl/fetch_queue.sv
// Fetch-to-decode packet queue: buffers 64-bit fetch packets with PC and predictions,
// presents the head as up to two instructions and supports consuming only slot 0.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clock_i,
  input  logic                     resetn_i,
  input  logic                     flush_i,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [63:0]              enq_data_i,
  input  logic [PC_W-1:0]          enq_pc_i,
  input  logic                     enq_pred_0_i,
  input  logic                     enq_pred_1_i,
  input  logic [PC_W-1:0]          enq_pred_tgt_0_i,
  input  logic [PC_W-1:0]          enq_pred_tgt_1_i,
  output logic                     deq_valid_o,
  output logic                     deq_slot1_valid_o,
  output logic [31:0]              deq_inst0_o,
  output logic [31:0]              deq_inst1_o,
  output logic [PC_W-1:0]          deq_pc_o,
  output logic                     deq_pred_0_o,
  output logic                     deq_pred_1_o,
  output logic [PC_W-1:0]          deq_pred_tgt_0_o,
  output logic [PC_W-1:0]          deq_pred_tgt_1_o,
  input  logic [1:0]               deq_take_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [63:0]     data_q    [DEPTH];
  logic [PC_W-1:0] pc_q      [DEPTH];
  logic [PC_W-1:0] tgt0_q    [DEPTH];
  logic [PC_W-1:0] tgt1_q    [DEPTH];
  logic            pred0_q   [DEPTH];
  logic            pred1_q   [DEPTH];
  logic [DEPTH-1:0] s1v_q;
  logic [DEPTH-1:0] ent_half_q;

  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q;
  logic          half_q;

  logic head_valid, head_half, head_s1v;
  logic do_enq, do_pop, do_half;

  assign head_valid = (count_q != '0);
  // half_q tracks a partial take; the stored bit covers packets that enter at pc+4
  assign head_half  = half_q | ent_half_q[head_q];
  assign head_s1v   = s1v_q[head_q] & ~head_half;

  assign enq_ready_o = (count_q != FULL_CNT);
  assign count_o     = count_q;

  always_comb begin
    do_enq  = enq_valid_i & enq_ready_o & ~flush_i;
    do_pop  = 1'b0;
    do_half = 1'b0;
    if (head_valid && !flush_i && deq_take_i != 2'd0) begin
      if (head_s1v && deq_take_i == 2'd1) do_half = 1'b1;
      else                                do_pop  = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (do_enq) begin
      data_q[tail_q] <= enq_data_i;
      pc_q[tail_q]   <= enq_pc_i;
      tgt0_q[tail_q] <= enq_pred_tgt_0_i;
      tgt1_q[tail_q] <= enq_pred_tgt_1_i;
      pred0_q[tail_q] <= enq_pred_0_i;
      pred1_q[tail_q] <= enq_pred_1_i;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      half_q     <= 1'b0;
      s1v_q      <= '0;
      ent_half_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      half_q  <= 1'b0;
    end else begin
      if (do_enq) begin
        s1v_q[tail_q]      <= ~enq_pred_0_i;
        ent_half_q[tail_q] <= enq_pc_i[2];
        tail_q             <= tail_q + AW'(1);
      end
      if (do_pop) begin
        head_q <= head_q + AW'(1);
        half_q <= 1'b0;
      end else if (do_half) begin
        half_q <= 1'b1;
      end
      case ({do_enq, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    deq_valid_o       = head_valid;
    deq_slot1_valid_o = 1'b0;
    deq_inst0_o       = '0;
    deq_inst1_o       = '0;
    deq_pc_o          = '0;
    deq_pred_0_o      = 1'b0;
    deq_pred_1_o      = 1'b0;
    deq_pred_tgt_0_o  = '0;
    deq_pred_tgt_1_o  = '0;
    if (head_valid) begin
      if (head_half) begin
        deq_inst0_o      = data_q[head_q][63:32];
        deq_pc_o         = pc_q[head_q] | PC_W'(4);
        deq_pred_0_o     = pred1_q[head_q];
        deq_pred_tgt_0_o = tgt1_q[head_q];
      end else begin
        deq_slot1_valid_o = s1v_q[head_q];
        deq_inst0_o       = data_q[head_q][31:0];
        deq_inst1_o       = data_q[head_q][63:32];
        deq_pc_o          = pc_q[head_q];
        deq_pred_0_o      = pred0_q[head_q];
        deq_pred_1_o      = pred1_q[head_q];
        deq_pred_tgt_0_o  = tgt0_q[head_q];
        deq_pred_tgt_1_o  = tgt1_q[head_q];
      end
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling queue between instruction memory and decode in the dual-issue core. It captures each 64-bit fetch packet (two 32-bit instructions) with its PC and branch predictions. It presents the head packet to decode/issue as up to two instructions, and supports partial consumption when issue accepts only slot 0. Decode-side stalls therefore no longer freeze the fetch PC, and a branch mispredict from execute flushes the whole queue in one cycle.

## Interface
- DEPTH, 4, number of packet entries; power of two, at least 2
- PC_W, 32, PC width
- clock_i  in  1  rising-edge clock
- resetn_i  in  1  asynchronous active-low reset
- flush_i  in  1  mispredict flush from execute (wrong_pred)
- enq_valid_i  in  1  fetch packet valid
- enq_ready_o  out  1  queue can accept a packet
- enq_data_i  in  64  [31:0] = inst at pc, [63:32] = inst at pc+4
- enq_pc_i  in  PC_W  packet PC; bit 2 set means entry into the upper word only
- enq_pred_0_i / enq_pred_1_i  in  1 each  predicted-taken, slot 0 / slot 1
- enq_pred_tgt_0_i / enq_pred_tgt_1_i  in  PC_W each  predicted targets
- deq_valid_o  out  1  head slot 0 holds a valid instruction
- deq_slot1_valid_o  out  1  head slot 1 also valid
- deq_inst0_o / deq_inst1_o  out  32 each  head instructions
- deq_pc_o  out  PC_W  PC of deq_inst0_o (slot 1 is deq_pc_o+4)
- deq_pred_0_o / deq_pred_1_o  out  1 each  head predictions
- deq_pred_tgt_0_o / deq_pred_tgt_1_o  out  PC_W each  head targets
- deq_take_i  in  2  instructions consumed this cycle: 0, 1 or 2
- count_o  out  log2(DEPTH)+1  occupied entries

## Operation
- Storage is a circular buffer with head and tail pointers, each log2(DEPTH) bits and wrapping modulo DEPTH. There is also an occupancy count and a per-head "half" flag, meaning the lower word has already been consumed.
- enq_ready_o = (count_o != DEPTH). There is no pass-through when full: a dequeue in the same cycle does not make room for an enqueue in that cycle.
- An enqueue happens when enq_valid_i && enq_ready_o && !flush_i. The packet is written at tail and tail advances.
- If enq_pc_i[2]=1, the entry is stored with half=1.
- Each entry stores a slot-1-valid bit = !enq_pred_0_i. A predicted-taken slot 0 bubbles slot 1.
- View of the head when half=0:
  - inst0 = data[31:0], inst1 = data[63:32]
  - pc = stored pc
  - preds and targets come straight from the entry
  - deq_slot1_valid_o = the entry's slot-1-valid bit
- View of the head when half=1:
  - inst0 = data[63:32]
  - pc = stored pc with bit 2 forced to 1
  - deq_pred_0_o / deq_pred_tgt_0_o = the entry's slot-1 values
  - deq_slot1_valid_o = 0; deq_inst1_o = 0; deq_pred_1_o = 0
- All deq_* data outputs are 0 when deq_valid_o = 0.
- Dequeue applies only when deq_valid_o = 1; deq_take_i is ignored when the queue is empty.
  - take=2 with slot 1 valid: pop the entry (head+1), and the new head's half flag comes from its stored half bit.
  - take=1 with slot 1 valid: set half=1 and do not pop.
  - take ≥ 1 with slot 1 invalid (either half=1 or bubble): pop.
  - take=2 with slot 1 invalid is treated as take=1.
  - take=3 is treated as 2.
- Simultaneous enqueue and pop: count is unchanged and both pointers move.
- flush_i has priority over everything. At the next edge, head=tail=0, count=0 and half=0. Any enqueue or dequeue in that cycle is discarded.

## Timing
- Reset (asynchronous, while resetn_i=0) gives:
  - head=tail=count=0, half=0
  - deq_valid_o=0, deq_slot1_valid_o=0, all deq data outputs 0
  - enq_ready_o=1, count_o=0
- Enqueue-to-dequeue latency is 1 cycle: a packet enqueued at edge N drives deq_valid_o=1 after edge N. There is no same-cycle bypass.
- deq_* outputs and enq_ready_o are combinational from registered state only. They never depend combinationally on enq_* or deq_take_i.
- Entry storage has no reset. The valid flag and the per-entry slot-1-valid bits are reset.
- Deasserting resetn_i mid-operation loses all entries. The first enqueue may occur on the first clock edge after release.
- Throughput is one packet enqueued and up to two instructions dequeued per cycle.

## Test plan
- Reset, then enqueue pc=0x100 with data {0x00200093, 0x00100013} and take=2 on the next cycle:
  - the cycle after enqueue shows deq_valid_o=1, inst0=0x00100013, inst1=0x00200093, pc=0x100, slot1 valid=1
  - the cycle after that shows deq_valid_o=0.
- Fill 4 packets with no take: enq_ready_o=0 and count_o=4. Then assert enq_valid_i together with take=2 for one cycle: nothing is accepted and count_o=3.
- Partial take on pc=0x200:
  - take=1 → next cycle pc=0x204, inst0 = old inst1, slot1 valid=0, pred_0 = old pred_1, count unchanged
  - take=1 again → pop.
- Enqueue pc=0x30C (odd word) with data upper 0xDEADBEEF: head shows inst0=0xDEADBEEF, pc=0x30C, slot1 valid=0; take=2 pops it.
- Enqueue with pred_0=1 and tgt_0=0x400: slot1 valid=0 and pred_tgt_0=0x400; take=1 pops.
- With 3 entries queued, assert flush_i together with enq_valid_i and take=2: the next cycle has count_o=0, deq_valid_o=0 and enq_ready_o=1, and the flush-cycle packet is absent. Then run pointer wrap-around: 10 enqueue/dequeue pairs in order, checking every PC.
